pamac_booth_seq: RTL and testbench
==================================

// Module: pamac_booth_seq
// PURPOSE
//  Stage directly upstream of the PAMAC control path. Accepts one activation/weight pair and radix-4
//  Booth-encodes both operands into raw 3-bit triplets (BPR_A/BPR_W), counting effective (nonzero) terms
//  (ETC_A/ETC_W). It then selects the operand to decompose and issues its nonzero digits one per beat as
//  BPEB_sel, with shift amount. Lets the control path and MAC skip zero Booth digits.
// PARAMETERS
//  DATA_W    16  operand width, even; NUM_DIG = DATA_W/2 Booth digits (8)
//  SEL_W     3   width of BPEB_sel, clog2(NUM_DIG)
//  ETC_BITS  4   width of ETC_A/ETC_W, holds 0..NUM_DIG
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst_n      in   1            synchronous reset, active low
//  in_valid   in   1            operand pair valid
//  in_ready   out  1            block can accept a pair (high only in IDLE)
//  act_in     in   DATA_W       activation, two's complement
//  wgt_in     in   DATA_W       weight, two's complement
//  MDecomp    in   1            1: choose decomposed operand by term count; 0: use AWDecomp
//  AWDecomp   in   1            forced select when MDecomp=0 (1 = decompose weight)
//  BPR_A      out  3*NUM_DIG    registered activation triplets, digit i at [3i+2:3i]
//  BPR_W      out  3*NUM_DIG    registered weight triplets, same packing
//  ETC_A      out  ETC_BITS     nonzero-digit count of activation
//  ETC_W      out  ETC_BITS     nonzero-digit count of weight
//  mul_sel    out  1            1 = weight decomposed, 0 = activation decomposed
//  BPEB_sel   out  SEL_W        digit index of current term
//  shift_amt  out  ETC_BITS     2*BPEB_sel
//  term_valid out  1            current term valid
//  term_ready in   1            downstream accepts term
//  term_last  out  1            current term is the final beat of this operation
//  zero_prod  out  1            selected operand has ETC=0; single beat, product is zero
// BEHAVIOUR
//  Booth triplet i = {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0. A digit is nonzero unless its triplet is 000 or 111.
//  ETC = popcount of the nonzero mask (0..8). Triplets are output raw, with no re-encoding.
//  Select: if MDecomp, mul_sel = (ETC_A > ETC_W), strictly, so a tie selects the activation.
//    Otherwise mul_sel = AWDecomp. Mode inputs are latched together with the operands.
//  FSM IDLE -> ENC -> ISSUE -> IDLE:
//   IDLE: in_ready=1. in_valid&in_ready latches act, wgt, MDecomp and AWDecomp, then goes to ENC.
//   ENC: one cycle. Registers BPR_*, ETC_*, mul_sel and rem_mask (nonzero mask of the selected operand).
//   ISSUE: term_valid=1 and BPEB_sel = index of the lowest set bit of rem_mask.
//     term_last=1 when exactly one bit remains.
//     On term_valid&term_ready, clear that bit. When the last term is accepted, go to IDLE.
//   ISSUE with empty rem_mask gives one beat: zero_prod=1, term_last=1, BPEB_sel=0, shift_amt=0.
//  Latency: accept at cycle N, first term_valid at N+2. An op takes ETC+2 cycles (min 3) with no stalls.
//  Stall: while term_valid&!term_ready, BPEB_sel, shift_amt, term_last and zero_prod hold.
//  BPR_*, ETC_* and mul_sel hold from ENC until the next ENC, stable for the whole ISSUE phase.
//  in_valid is ignored outside IDLE, with no buffering, and the operands are not captured.
//  Reset (any state, including mid-ISSUE): state=IDLE. in_ready=1 from the first cycle after reset.
//    term_valid=0, term_last=0, zero_prod=0, mul_sel=0, BPEB_sel=0, shift_amt=0.
//    BPR_A=BPR_W=0, ETC_A=ETC_W=0, rem_mask=0. A partially issued op is dropped.
// TESTING
//  1. act=0x0003, wgt=0x0001, MDecomp=1: ETC_A=2, ETC_W=1, mul_sel=1.
//     One beat: BPEB_sel=0, shift=0, code 010, term_last=1.
//  2. act=0x0003, wgt=0x0003, MDecomp=1 (tie): mul_sel=0.
//     Beats: sel 0 (triplet 110), then sel 1 (001, last). BPR_A[5:0]=6'b001110.
//  3. act=0x0000, wgt=0x1234, MDecomp=1: ETC_A=0, mul_sel=0.
//     Single beat with zero_prod=1, term_last=1, BPEB_sel=0.
//  4. act=0xFFFF (ETC=1, digit0=110), wgt=0x5555 (ETC=8, all 010), MDecomp=0, AWDecomp=1:
//     8 beats with sel 0..7, shift 0,2,..,14; last on sel 7.
//  5. Case 4 with term_ready low for 3 cycles at sel 2: outputs hold; then sel 3 follows. in_valid ignored.
//  6. Assert rst_n=0 for one cycle during beat sel 4 of case 4: the next cycle shows the full reset state.
//     A new pair is accepted cleanly afterwards.

Source files
------------

// File: rtl/pamac_booth_seq.sv
// Radix-4 Booth pre-encoder ahead of the PAMAC control path. It encodes both operands and
// issues the nonzero digits of the operand it picks, one per beat.
//   state   | meaning
//   S_IDLE  | waiting for an operand pair, in_ready high
//   S_ENC   | one cycle: register triplets, counts, select and remaining-digit mask
//   S_ISSUE | present one nonzero digit per beat until the last one is accepted
module pamac_booth_seq #(
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 3,
  parameter int ETC_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            act_in,
  input  logic [DATA_W-1:0]            wgt_in,
  input  logic                         MDecomp,
  input  logic                         AWDecomp,
  output logic [3*(DATA_W/2)-1:0]      BPR_A,
  output logic [3*(DATA_W/2)-1:0]      BPR_W,
  output logic [ETC_BITS-1:0]          ETC_A,
  output logic [ETC_BITS-1:0]          ETC_W,
  output logic                         mul_sel,
  output logic [SEL_W-1:0]             BPEB_sel,
  output logic [ETC_BITS-1:0]          shift_amt,
  output logic                         term_valid,
  input  logic                         term_ready,
  output logic                         term_last,
  output logic                         zero_prod
);

  localparam int NUM_DIG = DATA_W / 2;
  localparam int TRIP_W  = 3 * NUM_DIG;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_ISSUE} state_t;

  function automatic logic [TRIP_W-1:0] booth_trip(input logic [DATA_W-1:0] x);
    logic [DATA_W:0]   ext;
    logic [TRIP_W-1:0] t;
    ext = {x, 1'b0};
    t   = '0;
    for (int i = 0; i < NUM_DIG; i++) t[3*i +: 3] = ext[2*i +: 3];
    return t;
  endfunction

  function automatic logic [NUM_DIG-1:0] nz_mask(input logic [TRIP_W-1:0] t);
    logic [NUM_DIG-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DIG; i++)
      m[i] = (t[3*i +: 3] != 3'b000) && (t[3*i +: 3] != 3'b111);
    return m;
  endfunction

  function automatic logic [ETC_BITS-1:0] pop(input logic [NUM_DIG-1:0] m);
    logic [ETC_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_DIG; i++) c = c + ETC_BITS'(m[i]);
    return c;
  endfunction

  // Descending scan so the lowest set bit wins.
  function automatic logic [SEL_W-1:0] low_idx(input logic [NUM_DIG-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) if (m[i]) idx = SEL_W'(i);
    return idx;
  endfunction

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    act_q, act_d, wgt_q, wgt_d;
  logic                 md_q, md_d, aw_q, aw_d;
  logic [TRIP_W-1:0]    bpr_a_q, bpr_a_d, bpr_w_q, bpr_w_d;
  logic [ETC_BITS-1:0]  etc_a_q, etc_a_d, etc_w_q, etc_w_d;
  logic                 mul_sel_q, mul_sel_d;
  logic [NUM_DIG-1:0]   rem_mask_q, rem_mask_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 in_ready_q, in_ready_d;
  logic                 term_valid_q, term_valid_d;
  logic                 term_last_q, term_last_d;
  logic                 zero_prod_q, zero_prod_d;

  logic [TRIP_W-1:0]    trip_a, trip_w;
  logic [NUM_DIG-1:0]   mask_a, mask_w, enc_mask, mask_nx;
  logic [ETC_BITS-1:0]  cnt_a, cnt_w, enc_cnt;
  logic                 enc_sel;

  assign trip_a   = booth_trip(act_q);
  assign trip_w   = booth_trip(wgt_q);
  assign mask_a   = nz_mask(trip_a);
  assign mask_w   = nz_mask(trip_w);
  assign cnt_a    = pop(mask_a);
  assign cnt_w    = pop(mask_w);
  assign enc_sel  = md_q ? (cnt_a > cnt_w) : aw_q;
  assign enc_mask = enc_sel ? mask_w : mask_a;
  assign enc_cnt  = enc_sel ? cnt_w : cnt_a;
  assign mask_nx  = rem_mask_q & ~(NUM_DIG'(1) << sel_q);

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    wgt_d        = wgt_q;
    md_d         = md_q;
    aw_d         = aw_q;
    bpr_a_d      = bpr_a_q;
    bpr_w_d      = bpr_w_q;
    etc_a_d      = etc_a_q;
    etc_w_d      = etc_w_q;
    mul_sel_d    = mul_sel_q;
    rem_mask_d   = rem_mask_q;
    sel_d        = sel_q;
    in_ready_d   = in_ready_q;
    term_valid_d = term_valid_q;
    term_last_d  = term_last_q;
    zero_prod_d  = zero_prod_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          act_d      = act_in;
          wgt_d      = wgt_in;
          md_d       = MDecomp;
          aw_d       = AWDecomp;
          in_ready_d = 1'b0;
          state_d    = S_ENC;
        end
      end
      S_ENC: begin
        bpr_a_d      = trip_a;
        bpr_w_d      = trip_w;
        etc_a_d      = cnt_a;
        etc_w_d      = cnt_w;
        mul_sel_d    = enc_sel;
        rem_mask_d   = enc_mask;
        sel_d        = low_idx(enc_mask);
        term_valid_d = 1'b1;
        term_last_d  = (enc_cnt <= ETC_BITS'(1));
        zero_prod_d  = (enc_cnt == '0);
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (term_ready) begin
          rem_mask_d = mask_nx;
          if (term_last_q) begin
            sel_d        = '0;
            term_valid_d = 1'b0;
            term_last_d  = 1'b0;
            zero_prod_d  = 1'b0;
            in_ready_d   = 1'b1;
            state_d      = S_IDLE;
          end else begin
            sel_d       = low_idx(mask_nx);
            term_last_d = (pop(mask_nx) == ETC_BITS'(1));
          end
        end
      end
      default: begin
        in_ready_d   = 1'b1;
        term_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      act_q        <= '0;
      wgt_q        <= '0;
      md_q         <= 1'b0;
      aw_q         <= 1'b0;
      bpr_a_q      <= '0;
      bpr_w_q      <= '0;
      etc_a_q      <= '0;
      etc_w_q      <= '0;
      mul_sel_q    <= 1'b0;
      rem_mask_q   <= '0;
      sel_q        <= '0;
      in_ready_q   <= 1'b1;
      term_valid_q <= 1'b0;
      term_last_q  <= 1'b0;
      zero_prod_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      wgt_q        <= wgt_d;
      md_q         <= md_d;
      aw_q         <= aw_d;
      bpr_a_q      <= bpr_a_d;
      bpr_w_q      <= bpr_w_d;
      etc_a_q      <= etc_a_d;
      etc_w_q      <= etc_w_d;
      mul_sel_q    <= mul_sel_d;
      rem_mask_q   <= rem_mask_d;
      sel_q        <= sel_d;
      in_ready_q   <= in_ready_d;
      term_valid_q <= term_valid_d;
      term_last_q  <= term_last_d;
      zero_prod_q  <= zero_prod_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign BPR_A      = bpr_a_q;
  assign BPR_W      = bpr_w_q;
  assign ETC_A      = etc_a_q;
  assign ETC_W      = etc_w_q;
  assign mul_sel    = mul_sel_q;
  assign BPEB_sel   = sel_q;
  assign shift_amt  = ETC_BITS'({sel_q, 1'b0});
  assign term_valid = term_valid_q;
  assign term_last  = term_last_q;
  assign zero_prod  = zero_prod_q;

endmodule

// File: tb/tb_pamac_booth_seq.sv
// Directed bench for pamac_booth_seq: hand-computed Booth triplets, counts, beat order,
// stall hold, ignored in_valid during an op, and reset in the middle of issue.
module tb_pamac_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] act_in, wgt_in;
  logic        MDecomp, AWDecomp;
  logic [23:0] BPR_A, BPR_W;
  logic [3:0]  ETC_A, ETC_W;
  logic        mul_sel;
  logic [2:0]  BPEB_sel;
  logic [3:0]  shift_amt;
  logic        term_valid, term_ready, term_last, zero_prod;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pamac_booth_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .wgt_in(wgt_in), .MDecomp(MDecomp), .AWDecomp(AWDecomp),
    .BPR_A(BPR_A), .BPR_W(BPR_W), .ETC_A(ETC_A), .ETC_W(ETC_W), .mul_sel(mul_sel),
    .BPEB_sel(BPEB_sel), .shift_amt(shift_amt), .term_valid(term_valid),
    .term_ready(term_ready), .term_last(term_last), .zero_prod(zero_prod)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_ready"},   in_ready,   1);
    check({tag, ".term_valid"}, term_valid, 0);
    check({tag, ".term_last"},  term_last,  0);
    check({tag, ".zero_prod"},  zero_prod,  0);
    check({tag, ".mul_sel"},    mul_sel,    0);
    check({tag, ".sel"},        BPEB_sel,   0);
    check({tag, ".shift"},      shift_amt,  0);
    check({tag, ".bpr_a"},      BPR_A,      0);
    check({tag, ".bpr_w"},      BPR_W,      0);
    check({tag, ".etc_a"},      ETC_A,      0);
    check({tag, ".etc_w"},      ETC_W,      0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first ISSUE beat.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] w,
                          input logic md, input logic aw);
    check({tag, ".idle_ready"}, in_ready, 1);
    act_in = a; wgt_in = w; MDecomp = md; AWDecomp = aw; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    act_in = 16'hDEAD; wgt_in = 16'hBEEF; MDecomp = ~md; AWDecomp = ~aw;
    check({tag, ".enc_no_valid"}, term_valid, 0);
    check({tag, ".enc_ready"},    in_ready,   0);
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input int sel, input logic last, input logic zp);
    check($sformatf("%s.b%0d.valid", tag, sel), term_valid, 1);
    check($sformatf("%s.b%0d.sel",   tag, sel), BPEB_sel,   sel);
    check($sformatf("%s.b%0d.shift", tag, sel), shift_amt,  2 * sel);
    check($sformatf("%s.b%0d.last",  tag, sel), term_last,  last);
    check($sformatf("%s.b%0d.zero",  tag, sel), zero_prod,  zp);
    @(negedge clk);
  endtask

  task automatic end_op(input string tag);
    check({tag, ".end_valid"}, term_valid, 0);
    check({tag, ".end_ready"}, in_ready,   1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; term_ready = 1'b1;
    act_in = '0; wgt_in = '0; MDecomp = 1'b0; AWDecomp = 1'b0;
    @(negedge clk);
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: activation has more terms, weight decomposed, single beat
    start_op("c1", 16'h0003, 16'h0001, 1'b1, 1'b0);
    check("c1.etc_a", ETC_A, 2);
    check("c1.etc_w", ETC_W, 1);
    check("c1.mul_sel", mul_sel, 1);
    check("c1.code", BPR_W[2:0], 3'b010);
    beat("c1", 0, 1'b1, 1'b0);
    end_op("c1");

    // 2: tie selects activation
    start_op("c2", 16'h0003, 16'h0003, 1'b1, 1'b1);
    check("c2.mul_sel", mul_sel, 0);
    check("c2.bpr_a", BPR_A, 24'h00000E);
    check("c2.bpr_w", BPR_W, 24'h00000E);
    beat("c2", 0, 1'b0, 1'b0);
    beat("c2", 1, 1'b1, 1'b0);
    end_op("c2");

    // 3: zero activation gives one zero-product beat
    start_op("c3", 16'h0000, 16'h1234, 1'b1, 1'b1);
    check("c3.etc_a", ETC_A, 0);
    check("c3.etc_w", ETC_W, 6);
    check("c3.mul_sel", mul_sel, 0);
    beat("c3", 0, 1'b1, 1'b1);
    end_op("c3");

    // 4: forced weight decomposition, all eight digits
    start_op("c4", 16'hFFFF, 16'h5555, 1'b0, 1'b1);
    check("c4.etc_a", ETC_A, 1);
    check("c4.etc_w", ETC_W, 8);
    check("c4.mul_sel", mul_sel, 1);
    check("c4.bpr_a", BPR_A, 24'hFFFFFE);
    check("c4.bpr_w", BPR_W, 24'h492492);
    for (int s = 0; s < 8; s++) beat("c4", s, s == 7, 1'b0);
    end_op("c4");

    // 5: stall at sel 2 while a new pair is offered
    start_op("c5", 16'hFFFF, 16'h5555, 1'b0, 1'b1);
    beat("c5", 0, 1'b0, 1'b0);
    beat("c5", 1, 1'b0, 1'b0);
    term_ready = 1'b0;
    in_valid = 1'b1; act_in = 16'h0007; wgt_in = 16'h0007; MDecomp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("c5.stall%0d.valid", k), term_valid, 1);
      check($sformatf("c5.stall%0d.sel", k),   BPEB_sel,   2);
      check($sformatf("c5.stall%0d.shift", k), shift_amt,  4);
      check($sformatf("c5.stall%0d.last", k),  term_last,  0);
      check($sformatf("c5.stall%0d.zero", k),  zero_prod,  0);
      check($sformatf("c5.stall%0d.ready", k), in_ready,   0);
    end
    term_ready = 1'b1;
    @(negedge clk);
    for (int s = 3; s < 8; s++) beat("c5", s, s == 7, 1'b0);
    in_valid = 1'b0;
    end_op("c5");
    check("c5.bpr_w_kept", BPR_W, 24'h492492);
    check("c5.etc_w_kept", ETC_W, 8);
    check("c5.mul_sel_kept", mul_sel, 1);

    // 6: reset during beat sel 4, then a clean op
    start_op("c6", 16'hFFFF, 16'h5555, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) beat("c6", s, 1'b0, 1'b0);
    check("c6.pre_rst_sel", BPEB_sel, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("c6.rst");
    @(negedge clk);
    check_reset_state("c6.post");
    start_op("c6b", 16'h0003, 16'h0001, 1'b1, 1'b0);
    check("c6b.etc_a", ETC_A, 2);
    check("c6b.mul_sel", mul_sel, 1);
    beat("c6b", 0, 1'b1, 1'b0);
    end_op("c6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
